// File: rtl/p2s_rr_scheduler.sv
// p2s_rr_scheduler: round-robin grant of NUM_REQ parallel-word sources onto one P2S serializer.
// Latency: accept in cycle t -> registered load pulse, word and grant id at t+1; next accept >= t+BUFFER_SIZE.
// Backpressure: o_req_ready is a combinational one-hot only in accept cycles; i_hold blocks new grants.
module p2s_rr_scheduler #(
    parameter int BUFFER_SIZE = 7,
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 16,
    localparam int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ*BUFFER_SIZE-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic                           i_hold,
    output logic [BUFFER_SIZE-1:0]         o_p2s_data,
    output logic                           o_p2s_dv,
    output logic [GID_W-1:0]               o_grant_id,
    output logic                           o_busy,
    output logic [CNT_W-1:0]               o_word_cnt
);

    localparam int SLOT_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [GID_W-1:0]    last_grant;
    logic [GID_W-1:0]    winner;
    logic [GID_W-1:0]    cand;
    logic                found;
    logic                eligible;
    logic                accept;

    // Search starts just after the previous winner so every source gets a turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && i_req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A new word may only load once the previous one has fully shifted out.
    assign eligible = (state_q == IDLE) || (slot_cnt == '0);
    assign accept   = eligible && !i_hold && found && !i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SERIAL;
            SERIAL:  if ((slot_cnt == '0) && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[winner] = 1'b1;
        end
        o_busy = (state_q == SERIAL);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_p2s_data <= '0;
            o_p2s_dv   <= 1'b0;
            o_grant_id <= '0;
            o_word_cnt <= '0;
            last_grant <= GID_W'(NUM_REQ - 1);
            slot_cnt   <= '0;
        end else begin
            o_p2s_dv <= accept;
            if (accept) begin
                o_p2s_data <= i_req_data[winner*BUFFER_SIZE +: BUFFER_SIZE];
                o_grant_id <= winner;
                last_grant <= winner;
                o_word_cnt <= o_word_cnt + CNT_W'(1);
                slot_cnt   <= SLOT_W'(BUFFER_SIZE - 1);
            end else if (slot_cnt != '0) begin
                slot_cnt <= slot_cnt - SLOT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Bench for p2s_rr_scheduler: directed scenarios plus randomized traffic against a time-based model.
module tb_p2s_rr_scheduler;
    localparam int BS = 7;
    localparam int NR = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NR*BS-1:0]  i_req_data;
    logic [NR-1:0]     i_req_valid;
    logic              i_hold;
    logic [NR-1:0]     o_req_ready;
    logic [BS-1:0]     o_p2s_data;
    logic              o_p2s_dv;
    logic [1:0]        o_grant_id;
    logic              o_busy;
    logic [15:0]       o_word_cnt;
    logic [NR-1:0]     w_req_ready;
    logic [BS-1:0]     w_p2s_data;
    logic              w_p2s_dv;
    logic [1:0]        w_grant_id;
    logic              w_busy;
    logic [3:0]        w_word_cnt;

    p2s_rr_scheduler #(.BUFFER_SIZE(BS), .NUM_REQ(NR), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_data(i_req_data), .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready), .i_hold(i_hold), .o_p2s_data(o_p2s_data), .o_p2s_dv(o_p2s_dv),
        .o_grant_id(o_grant_id), .o_busy(o_busy), .o_word_cnt(o_word_cnt)
    );

    p2s_rr_scheduler #(.BUFFER_SIZE(BS), .NUM_REQ(NR), .CNT_W(4)) dut_w (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_data(i_req_data), .i_req_valid(i_req_valid),
        .o_req_ready(w_req_ready), .i_hold(i_hold), .o_p2s_data(w_p2s_data), .o_p2s_dv(w_p2s_dv),
        .o_grant_id(w_grant_id), .o_busy(w_busy), .o_word_cnt(w_word_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a source may be granted once BS cycles have passed since the last grant.
    int            m_cyc = 0;
    int            m_last_acc;
    int            m_last_grant;
    int            m_total;
    int            m_gid;
    int            m_win;
    bit            m_acc;
    bit            m_dv;
    logic [BS-1:0] m_data;
    logic [BS-1:0] m_word;
    logic [NR-1:0] m_ready;

    function automatic bit m_busy();
        return (m_last_acc >= 0) && (m_cyc - m_last_acc >= 1) && (m_cyc - m_last_acc <= BS);
    endfunction

    task automatic model_reset();
        m_last_acc   = -100;
        m_last_grant = NR - 1;
        m_total      = 0;
        m_gid        = 0;
        m_data       = '0;
        m_dv         = 1'b0;
        m_acc        = 1'b0;
    endtask

    task automatic apply(input logic [NR-1:0] v, input logic [NR*BS-1:0] d, input logic h);
        i_req_valid = v;
        i_req_data  = d;
        i_hold      = h;
        m_acc   = 1'b0;
        m_win   = 0;
        m_ready = '0;
        if (!h && (m_last_acc < 0 || m_cyc - m_last_acc >= BS)) begin
            for (int i = 1; i <= NR; i++) begin
                int k;
                k = (m_last_grant + i) % NR;
                if (!m_acc && v[k]) begin
                    m_acc = 1'b1;
                    m_win = k;
                end
            end
        end
        if (m_acc) begin
            m_ready[m_win] = 1'b1;
            m_word = d[m_win*BS +: BS];
        end
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (m_acc) begin
            m_data       = m_word;
            m_gid        = m_win;
            m_last_grant = m_win;
            m_last_acc   = m_cyc;
            m_total++;
        end
        m_dv  = m_acc;
        m_acc = 1'b0;
        m_cyc++;
        #1;
    endtask

    task automatic assert_reset(input logic [NR-1:0] v);
        i_rst       = 1'b1;
        i_req_valid = v;
        i_req_data  = {NR{7'h5A}};
        i_hold      = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst       = 1'b0;
        i_req_valid = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < BS + 2; i++) begin
            apply('0, '0, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        assert_reset(4'hF);
        n_tests++;
        if (o_req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
        n_tests++;
        if ({o_p2s_data, o_p2s_dv, o_grant_id, o_busy} !== '0) begin
            n_fail++; $display("FAIL reset_outs: data=%h dv=%b gid=%0d busy=%b want all 0", o_p2s_data, o_p2s_dv, o_grant_id, o_busy);
        end
        n_tests++;
        if (o_word_cnt !== 16'd0 || w_word_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", o_word_cnt, w_word_cnt);
        end
        @(posedge i_clk);
        #1;
        n_tests++;
        if ({o_req_ready, o_p2s_dv, o_busy, o_word_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_held: ready=%b dv=%b busy=%b cnt=%0d want 0", o_req_ready, o_p2s_dv, o_busy, o_word_cnt);
        end
        release_reset();
    endtask

    task automatic test_single();
        logic [NR*BS-1:0] d;
        assert_reset('0);
        release_reset();
        d = '0;
        d[1*BS +: BS] = 7'h55;
        apply(4'b0010, d, 1'b0);
        n_tests++;
        if (o_req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b want 0010", o_req_ready); end
        tick();
        n_tests++;
        if (o_p2s_dv !== 1'b1 || o_p2s_data !== 7'h55 || o_grant_id !== 2'd1) begin
            n_fail++; $display("FAIL single_load: dv=%b data=%h gid=%0d want 1/55/1", o_p2s_dv, o_p2s_data, o_grant_id);
        end
        for (int t = 1; t <= 7; t++) begin
            apply('0, d, 1'b0);
            tick();
            if (t + 1 == 2) begin
                n_tests++;
                if (o_p2s_dv !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: dv=%b at t2 want 0", o_p2s_dv); end
            end
            if (t + 1 == 7) begin
                n_tests++;
                if (o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t7: got %b want 1", o_busy); end
            end
            if (t + 1 == 8) begin
                n_tests++;
                if (o_busy !== 1'b0 || o_word_cnt !== 16'd1) begin
                    n_fail++; $display("FAIL single_end_t8: busy=%b cnt=%0d want 0/1", o_busy, o_word_cnt);
                end
            end
        end
    endtask

    task automatic test_rr_all();
        logic [NR*BS-1:0] d;
        logic [NR-1:0]    er;
        int               g;
        assert_reset('0);
        release_reset();
        for (int k = 0; k < NR; k++) d[k*BS +: BS] = BS'(8'h10 + k);
        for (int t = 0; t <= 29; t++) begin
            apply(4'hF, d, 1'b0);
            er = '0;
            g  = (t / BS) % NR;
            if (t % BS == 0) er[g] = 1'b1;
            n_tests++;
            if (o_req_ready !== er) begin n_fail++; $display("FAIL rr_ready t=%0d: got %b want %b", t, o_req_ready, er); end
            tick();
            n_tests++;
            if (o_p2s_dv !== (t % BS == 0) || o_busy !== 1'b1) begin
                n_fail++; $display("FAIL rr_pulse t=%0d: dv=%b busy=%b want %b/1", t + 1, o_p2s_dv, o_busy, (t % BS == 0));
            end
            if (t % BS == 0) begin
                n_tests++;
                if (o_grant_id !== 2'(g) || o_p2s_data !== BS'(8'h10 + g)) begin
                    n_fail++; $display("FAIL rr_grant t=%0d: gid=%0d data=%h want %0d/%h", t + 1, o_grant_id, o_p2s_data, g, 8'h10 + g);
                end
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [NR*BS-1:0] d;
        int first;
        int second;
        first  = -1;
        second = -1;
        assert_reset('0);
        release_reset();
        d = '0;
        d[2*BS +: BS] = 7'h01;
        for (int t = 0; t <= 15; t++) begin
            if (t == 1) d[2*BS +: BS] = 7'h7F;
            apply((second < 0) ? 4'b0100 : 4'b0000, d, 1'b0);
            if (o_req_ready[2]) begin
                if (first < 0) first = t;
                else if (second < 0) second = t;
            end
            tick();
            if (t == second) begin
                n_tests++;
                if (o_p2s_dv !== 1'b1 || o_p2s_data !== 7'h7F) begin
                    n_fail++; $display("FAIL b2b_second_word: dv=%b data=%h want 1/7f", o_p2s_dv, o_p2s_data);
                end
            end
        end
        n_tests++;
        if (first !== 0 || second - first !== BS) begin
            n_fail++; $display("FAIL b2b_spacing: first=%0d second=%0d want 0/7", first, second);
        end
        drain();
    endtask

    task automatic test_hold();
        logic [NR*BS-1:0] d;
        assert_reset('0);
        release_reset();
        d = '0;
        d[0*BS +: BS] = 7'h2A;
        d[3*BS +: BS] = 7'h33;
        apply(4'b0001, d, 1'b0);
        n_tests++;
        if (o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL hold_first_ready: got %b want 0001", o_req_ready); end
        tick();
        for (int t = 1; t <= 11; t++) begin
            apply(4'b1000, d, t >= 3);
            n_tests++;
            if (o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_ready t=%0d: got %b want 0000", t, o_req_ready); end
            tick();
            if (t + 1 == 7 || t + 1 == 8) begin
                n_tests++;
                if (o_busy !== (t + 1 == 7)) begin n_fail++; $display("FAIL hold_busy t=%0d: got %b want %b", t + 1, o_busy, (t + 1 == 7)); end
            end
        end
        apply(4'b1000, d, 1'b0);
        n_tests++;
        if (o_req_ready !== 4'b1000) begin n_fail++; $display("FAIL hold_release_ready: got %b want 1000", o_req_ready); end
        tick();
        n_tests++;
        if (o_p2s_dv !== 1'b1 || o_grant_id !== 2'd3 || o_p2s_data !== 7'h33) begin
            n_fail++; $display("FAIL hold_release_load: dv=%b gid=%0d data=%h want 1/3/33", o_p2s_dv, o_grant_id, o_p2s_data);
        end
        drain();
    endtask

    task automatic test_reset_midword();
        logic [NR*BS-1:0] d;
        assert_reset('0);
        release_reset();
        d = '0;
        d[0*BS +: BS] = 7'h0A;
        d[1*BS +: BS] = 7'h11;
        d[2*BS +: BS] = 7'h22;
        apply(4'b0010, d, 1'b0);
        tick();
        for (int t = 1; t <= 3; t++) begin
            apply(4'b0101, d, 1'b0);
            tick();
        end
        assert_reset(4'b0101);
        n_tests++;
        if ({o_req_ready, o_p2s_data, o_p2s_dv, o_grant_id, o_busy, o_word_cnt} !== '0) begin
            n_fail++; $display("FAIL midreset_outs: ready=%b data=%h dv=%b gid=%0d busy=%b cnt=%0d want all 0",
                               o_req_ready, o_p2s_data, o_p2s_dv, o_grant_id, o_busy, o_word_cnt);
        end
        release_reset();
        apply(4'b0101, d, 1'b0);
        n_tests++;
        if (o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL midreset_first_grant: got %b want 0001", o_req_ready); end
        tick();
        n_tests++;
        if (o_grant_id !== 2'd0 || o_p2s_data !== 7'h0A || o_word_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midreset_load: gid=%0d data=%h cnt=%0d want 0/0a/1", o_grant_id, o_p2s_data, o_word_cnt);
        end
        drain();
    endtask

    task automatic test_random();
        logic [NR*BS-1:0] d;
        logic [NR-1:0]    v;
        int last_pulse;
        last_pulse = -1;
        assert_reset('0);
        release_reset();
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            d = (NR*BS)'($urandom);
            apply(v, d, $urandom_range(0, 9) == 0);
            n_tests++;
            if (o_req_ready !== m_ready) begin n_fail++; $display("FAIL rand_ready n=%0d: got %b want %b", n, o_req_ready, m_ready); end
            tick();
            n_tests++;
            if (o_p2s_dv !== m_dv || o_p2s_data !== m_data || o_grant_id !== 2'(m_gid) || o_busy !== m_busy()) begin
                n_fail++; $display("FAIL rand_outs n=%0d: dv=%b data=%h gid=%0d busy=%b want %b/%h/%0d/%b",
                                   n, o_p2s_dv, o_p2s_data, o_grant_id, o_busy, m_dv, m_data, m_gid, m_busy());
            end
            n_tests++;
            if (o_word_cnt !== 16'(m_total) || w_word_cnt !== 4'(m_total)) begin
                n_fail++; $display("FAIL rand_cnt n=%0d: got %0d/%0d want %0d/%0d", n, o_word_cnt, w_word_cnt, 16'(m_total), 4'(m_total));
            end
            if (o_p2s_dv === 1'b1) begin
                if (last_pulse >= 0) begin
                    n_tests++;
                    if (m_cyc - last_pulse < BS) begin
                        n_fail++; $display("FAIL rand_spacing n=%0d: gap %0d want >= %0d", n, m_cyc - last_pulse, BS);
                    end
                end
                last_pulse = m_cyc;
            end
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [NR*BS-1:0] d;
        assert_reset('0);
        release_reset();
        d = '0;
        d[0*BS +: BS] = 7'h3C;
        for (int t = 0; t <= 16 * BS; t++) begin
            apply(4'b0001, d, 1'b0);
            tick();
        end
        n_tests++;
        if (w_word_cnt !== 4'd1 || o_word_cnt !== 16'd17) begin
            n_fail++; $display("FAIL wrap_cnt: got %0d/%0d want 1/17", w_word_cnt, o_word_cnt);
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_data  = '0;
        i_hold      = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rr_all();
        test_back_to_back();
        test_hold();
        test_reset_midword();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
